// File: rtl/ram_port_arbiter_pkg.sv
// Shared types and constants for the two-client RAM port arbiter.
package ram_port_arbiter_pkg;

   localparam int DEF_WIDTHAD = 16;
   localparam int DEF_WIDTH   = 32;
   localparam int RESP_DEPTH  = 2;

   typedef enum logic {
      CLIENT_FETCH = 1'b0,
      CLIENT_LSU   = 1'b1
   } client_e;

   typedef struct packed {
      logic                   we;
      logic [DEF_WIDTHAD-1:0] addr;
      logic [DEF_WIDTH-1:0]   wdata;
   } req_t;

endpackage

// File: rtl/ram_port_arbiter_if.sv
// One client's request and read-response channels; master = client, slave = arbiter.
interface ram_port_arbiter_if #(
   parameter int widthad = 16,
   parameter int width   = 32
);
   logic               req_valid;
   logic               req_ready;
   logic               req_we;
   logic [widthad-1:0] req_addr;
   logic [width-1:0]   req_wdata;
   logic               resp_valid;
   logic               resp_ready;
   logic [width-1:0]   resp_data;

   modport master (
      output req_valid, req_we, req_addr, req_wdata, resp_ready,
      input  req_ready, resp_valid, resp_data
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, resp_ready,
      output req_ready, resp_valid, resp_data
   );
endinterface

// File: rtl/ram_port_arbiter_resp_fifo.sv
// Small synchronous response FIFO with occupancy output; head data is stable until popped.
module ram_port_arbiter_resp_fifo #(
   parameter int width = 32,
   parameter int DEPTH = 2
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         push,
   input  logic [width-1:0]             push_data,
   input  logic                         pop,
   output logic                         valid,
   output logic [width-1:0]             data,
   output logic [$clog2(DEPTH+1)-1:0]   count
);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [width-1:0] mem_r [DEPTH];
   logic [PTR_W-1:0] wr_ptr_r;
   logic [PTR_W-1:0] rd_ptr_r;
   logic [CNT_W-1:0] count_r;
   logic             pop_ok_s;

   function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
      if (p == PTR_W'(DEPTH - 1)) begin
         return {PTR_W{1'b0}};
      end else begin
         return p + PTR_W'(1);
      end
   endfunction

   assign valid    = (count_r != {CNT_W{1'b0}});
   assign pop_ok_s = pop & valid;
   assign data     = mem_r[rd_ptr_r];
   assign count    = count_r;

   // Storage, pointers and occupancy
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= {width{1'b0}};
         end
         wr_ptr_r <= {PTR_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
         count_r  <= {CNT_W{1'b0}};
      end else begin
         if (push) begin
            mem_r[wr_ptr_r] <= push_data;
            wr_ptr_r        <= ptr_next(wr_ptr_r);
         end
         if (pop_ok_s) begin
            rd_ptr_r <= ptr_next(rd_ptr_r);
         end
         case ({push, pop_ok_s})
            2'b10:   count_r <= count_r + CNT_W'(1);
            2'b01:   count_r <= count_r - CNT_W'(1);
            default: count_r <= count_r;
         endcase
      end
   end
endmodule

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one RAM port between a fetch and a load/store client.
// Absorbs the RAM's one-cycle read latency and buffers read responses per client.
module ram_port_arbiter #(
   parameter int widthad    = ram_port_arbiter_pkg::DEF_WIDTHAD,
   parameter int width      = ram_port_arbiter_pkg::DEF_WIDTH,
   parameter int RESP_DEPTH = ram_port_arbiter_pkg::RESP_DEPTH
) (
   input  logic                  clk,
   input  logic                  rst,
   ram_port_arbiter_if.slave     c0,
   ram_port_arbiter_if.slave     c1,
   output logic [widthad-1:0]    ram_address,
   output logic                  ram_wren,
   output logic [width-1:0]      ram_data,
   output logic                  ram_rden,
   input  logic [width-1:0]      ram_q
);
   import ram_port_arbiter_pkg::*;

   localparam int CNT_W = $clog2(RESP_DEPTH + 1);

   client_e            ptr_r;
   client_e            infl_id_r;
   logic               infl_valid_r;
   logic [widthad-1:0] last_addr_r;
   logic [width-1:0]   last_data_r;

   logic [CNT_W-1:0]   cnt0_s, cnt1_s, out0_s, out1_s;
   logic               pop0_s, pop1_s, push0_s, push1_s;
   logic               credit0_s, credit1_s, elig0_s, elig1_s;
   logic               gnt0_s, gnt1_s, gnt_any_s;
   req_t               req_s;

   // Outstanding reads = tagged in-flight read plus buffered responses
   assign pop0_s  = c0.resp_valid & c0.resp_ready;
   assign pop1_s  = c1.resp_valid & c1.resp_ready;
   assign push0_s = infl_valid_r & (infl_id_r == CLIENT_FETCH);
   assign push1_s = infl_valid_r & (infl_id_r == CLIENT_LSU);
   assign out0_s  = cnt0_s + CNT_W'(push0_s);
   assign out1_s  = cnt1_s + CNT_W'(push1_s);

   // Eligibility and round-robin grant; a same-cycle pop frees a credit
   always_comb begin
      credit0_s = (out0_s < CNT_W'(RESP_DEPTH)) || ((out0_s == CNT_W'(RESP_DEPTH)) && pop0_s);
      credit1_s = (out1_s < CNT_W'(RESP_DEPTH)) || ((out1_s == CNT_W'(RESP_DEPTH)) && pop1_s);
      elig0_s   = ~rst & c0.req_valid & (c0.req_we | credit0_s);
      elig1_s   = ~rst & c1.req_valid & (c1.req_we | credit1_s);
      if (elig0_s && elig1_s) begin
         gnt0_s = (ptr_r == CLIENT_FETCH);
         gnt1_s = (ptr_r == CLIENT_LSU);
      end else begin
         gnt0_s = elig0_s;
         gnt1_s = elig1_s;
      end
      gnt_any_s = gnt0_s | gnt1_s;
   end

   // Granted request selection
   always_comb begin
      req_s = '{we: 1'b0, addr: {widthad{1'b0}}, wdata: {width{1'b0}}};
      if (gnt1_s) begin
         req_s = '{we: c1.req_we, addr: c1.req_addr, wdata: c1.req_wdata};
      end else begin
         req_s = '{we: c0.req_we, addr: c0.req_addr, wdata: c0.req_wdata};
      end
   end

   assign c0.req_ready = gnt0_s;
   assign c1.req_ready = gnt1_s;
   assign ram_wren     = gnt_any_s & req_s.we;
   assign ram_rden     = gnt_any_s & ~req_s.we;
   assign ram_address  = gnt_any_s ? req_s.addr  : last_addr_r;
   assign ram_data     = gnt_any_s ? req_s.wdata : last_data_r;

   // Pointer, in-flight read tag, and idle-cycle address/data hold
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_r        <= CLIENT_FETCH;
         infl_valid_r <= 1'b0;
         infl_id_r    <= CLIENT_FETCH;
         last_addr_r  <= {widthad{1'b0}};
         last_data_r  <= {width{1'b0}};
      end else begin
         if (gnt0_s) begin
            ptr_r <= CLIENT_LSU;
         end else if (gnt1_s) begin
            ptr_r <= CLIENT_FETCH;
         end
         infl_valid_r <= ram_rden;
         infl_id_r    <= gnt1_s ? CLIENT_LSU : CLIENT_FETCH;
         if (gnt_any_s) begin
            last_addr_r <= req_s.addr;
            last_data_r <= req_s.wdata;
         end
      end
   end

   ram_port_arbiter_resp_fifo #(.width(width), .DEPTH(RESP_DEPTH)) u_fifo0 (
      .clk       (clk),
      .rst       (rst),
      .push      (push0_s),
      .push_data (ram_q),
      .pop       (c0.resp_ready),
      .valid     (c0.resp_valid),
      .data      (c0.resp_data),
      .count     (cnt0_s)
   );

   ram_port_arbiter_resp_fifo #(.width(width), .DEPTH(RESP_DEPTH)) u_fifo1 (
      .clk       (clk),
      .rst       (rst),
      .push      (push1_s),
      .push_data (ram_q),
      .pop       (c1.resp_ready),
      .valid     (c1.resp_valid),
      .data      (c1.resp_data),
      .count     (cnt1_s)
   );
endmodule
